// File: rtl/fifo_ddr_burst_writer_pkg.sv
// Shared constants for the HDMI capture DDR burst writer: FSM encodings and AXI
// response codes.
package fifo_ddr_wr_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam int BYTES_PER_BEAT = 4;

  localparam logic [1:0] OKAY = 2'b00;

endpackage

// File: rtl/fifo_ddr_burst_writer_skid.sv
// Two-entry data buffer with push/pop/count, decoupling a registered-latency
// source from a ready/valid sink.
module wr_skid_buf_2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             tb_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = ent0;

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else begin
      if (do_pop && do_push) begin
        if (count == 2'd1) begin
          ent0 <= push_data;
        end else begin
          ent0 <= ent1;
          ent1 <= push_data;
        end
      end else if (do_pop) begin
        ent0  <= ent1;
        count <= count - 2'd1;
      end else if (do_push) begin
        if (count == 2'd0) ent0 <= push_data;
        else               ent1 <= push_data;
        count <= count + 2'd1;
      end
    end
  end

endmodule

// File: rtl/fifo_ddr_burst_writer.sv
// Drains the pixel FIFO read side into fixed-length AXI write bursts, advancing
// a frame address that wraps to FRAME_BASE at the end of every frame.
//
// state | meaning
// IDLE  | waiting for at least BURST_LEN words in the FIFO
// ADDR  | presenting the burst address until accepted
// DATA  | fetching and streaming exactly BURST_LEN beats
// RESP  | waiting for the write response, then advancing the address
module fifo_ddr_burst_writer
  import fifo_ddr_wr_pkg::*;
#(
  parameter int                    DATA_WIDTH  = BYTES_PER_BEAT * 8,
  parameter int                    LEVEL_WIDTH = 12,
  parameter int                    ADDR_WIDTH  = 28,
  parameter int                    BURST_LEN   = 16,
  parameter logic [ADDR_WIDTH-1:0] FRAME_BASE  = 28'h0000000,
  parameter int                    FRAME_WORDS = 1036800
) (
  input  logic                   clk,
  input  logic                   tb_rst,
  input  logic                   frame_start,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                   fifo_rd_en,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic [ADDR_WIDTH-1:0]  m_awaddr,
  output logic [7:0]             m_awlen,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [DATA_WIDTH-1:0]  m_wdata,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  output logic                   m_wlast,
  input  logic                   m_bvalid,
  output logic                   m_bready,
  input  logic [1:0]             m_bresp,
  output logic                   frame_done,
  output logic                   resp_err,
  output logic                   busy
);

  localparam int CNT_W   = $clog2(BURST_LEN + 1);
  localparam int WORDS_W = $clog2(FRAME_WORDS + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WORDS_W-1:0]    words_q;
  logic [WORDS_W-1:0]    words_next;
  logic                  frame_wrap;
  logic [CNT_W-1:0]      fetch_rem;
  logic [CNT_W-1:0]      beats_left;
  logic                  inflight;
  logic                  restart_pend;
  logic [1:0]            skid_count;
  logic [2:0]            occupancy;
  logic                  w_fire;

  wr_skid_buf_2 #(.WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .tb_rst    (tb_rst),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .pop       (w_fire),
    .head      (m_wdata),
    .count     (skid_count)
  );

  assign m_wvalid  = (skid_count != 2'd0);
  assign w_fire    = m_wvalid && m_wready;
  assign m_wlast   = m_wvalid && (beats_left == CNT_W'(1));
  assign m_awvalid = (state == ST_ADDR);
  assign m_awaddr  = addr_q;
  assign m_awlen   = 8'(BURST_LEN - 1);
  assign m_bready  = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  // A beat leaving the buffer this cycle frees the slot the new read will need,
  // which is what keeps the stream gap-free while m_wready stays high.
  assign occupancy  = 3'(skid_count) + 3'(inflight);
  assign fifo_rd_en = (state == ST_DATA) && (fetch_rem != '0) && !fifo_rd_empty &&
                      (occupancy < (3'd2 + 3'(w_fire)));

  assign words_next = words_q + WORDS_W'(BURST_LEN);
  assign frame_wrap = (words_next == WORDS_W'(FRAME_WORDS));

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state        <= ST_IDLE;
      addr_q       <= FRAME_BASE;
      words_q      <= '0;
      fetch_rem    <= '0;
      beats_left   <= '0;
      inflight     <= 1'b0;
      restart_pend <= 1'b0;
      frame_done   <= 1'b0;
      resp_err     <= 1'b0;
    end else begin
      inflight   <= fifo_rd_en;
      frame_done <= 1'b0;
      if (fifo_rd_en) fetch_rem <= fetch_rem - CNT_W'(1);
      if (w_fire)     beats_left <= beats_left - CNT_W'(1);
      if (frame_start && (state != ST_IDLE)) restart_pend <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            addr_q  <= FRAME_BASE;
            words_q <= '0;
          end
          if (fifo_rd_water_level >= LEVEL_WIDTH'(BURST_LEN)) state <= ST_ADDR;
        end
        ST_ADDR: begin
          if (m_awready) begin
            state      <= ST_DATA;
            fetch_rem  <= CNT_W'(BURST_LEN);
            beats_left <= CNT_W'(BURST_LEN);
          end
        end
        ST_DATA: begin
          if (w_fire && m_wlast) state <= ST_RESP;
        end
        ST_RESP: begin
          if (m_bvalid) begin
            // Errored bursts are dropped, not retried: the address moves on regardless.
            if (m_bresp != OKAY) resp_err <= 1'b1;
            state        <= ST_IDLE;
            restart_pend <= 1'b0;
            frame_done   <= frame_wrap;
            if (restart_pend || frame_start || frame_wrap) begin
              addr_q  <= FRAME_BASE;
              words_q <= '0;
            end else begin
              addr_q  <= addr_q + ADDR_STEP;
              words_q <= words_next;
            end
          end
        end
      endcase
    end
  end

endmodule
